// File: rtl/addsub_sched_pkg.sv
// Shared definitions for the round-robin add/subtract scheduler: opcodes,
// response-slot states and the round-robin pointer step.
package addsub_sched_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Index following idx, wrapping at num_req.
  function automatic int unsigned next_rr_idx(input int unsigned idx, input int unsigned num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/addsub_rr_scheduler_if.sv
// Request/response bundle between the issuing engines (master) and the
// shared add/subtract scheduler (slave).
interface addsub_rr_scheduler_if #(
  parameter int unsigned N       = 8,
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ-1:0]   req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [N-1:0]         rsp_result;
  logic                 rsp_carry;
  logic                 rsp_ovf;
  logic [ID_W-1:0]      rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id
  );

endinterface

// File: rtl/nbit_add_sub.sv
// Combinational N-bit adder/subtractor: {carry, result} = a + (op ? ~b : b) + op.
module nbit_add_sub
  import addsub_sched_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic [N-1:0] result_c,
  output logic         carry_c
);

  logic [N-1:0] b_eff;

  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign {carry_c, result_c} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, op};

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one add/subtract datapath among NUM_REQ
// requesters, with a single registered, backpressured response slot.
module addsub_rr_scheduler
  import addsub_sched_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input logic                  clk,
  input logic                  rst,
  addsub_rr_scheduler_if.slave bus
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  slot_state_t     slot_q;
  slot_state_t     slot_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] win_hi;
  logic [ID_W-1:0] win_lo;
  logic            found_hi;
  logic            found;
  logic            can_issue;
  logic            grant;

  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic            op_sel;
  logic [N-1:0]    sum_c;
  logic            carry_c;
  logic            b_eff_msb;
  logic            ovf_c;

  logic [N-1:0]    result_q;
  logic            carry_q;
  logic            ovf_q;
  logic [ID_W-1:0] id_q;

  // Search from rr_ptr upward; if nothing there, the lowest valid index wraps in.
  always_comb begin
    found_hi = 1'b0;
    found    = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && !found_hi && (ID_W'(i) >= rr_ptr)) begin
        found_hi = 1'b1;
        win_hi   = ID_W'(i);
      end
      if (bus.req_valid[i] && !found) begin
        found  = 1'b1;
        win_lo = ID_W'(i);
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  assign can_issue = (slot_q == SLOT_EMPTY) || bus.rsp_ready;
  assign grant     = found && can_issue && !rst;

  always_comb begin
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = grant && (winner == ID_W'(i));
    end
  end

  // Winner operand mux; depends only on rr_ptr/req_valid, never feeds req_ready.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = OP_ADD;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        a_sel  = bus.req_a[i*N +: N];
        b_sel  = bus.req_b[i*N +: N];
        op_sel = bus.req_op[i];
      end
    end
  end

  nbit_add_sub #(.N(N)) u_add_sub (
    .a        (a_sel),
    .b        (b_sel),
    .op       (op_sel),
    .result_c (sum_c),
    .carry_c  (carry_c)
  );

  assign b_eff_msb = (op_sel == OP_ADD) ? b_sel[N-1] : ~b_sel[N-1];
  assign ovf_c     = (a_sel[N-1] == b_eff_msb) && (sum_c[N-1] != a_sel[N-1]);

  always_ff @(posedge clk) begin
    if (rst) slot_q <= SLOT_EMPTY;
    else     slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (grant) slot_d = SLOT_FULL;
      SLOT_FULL:  if (!grant && bus.rsp_ready) slot_d = SLOT_EMPTY;
    endcase
  end

  // Response payload and arbitration pointer move only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      id_q     <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      result_q <= sum_c;
      carry_q  <= carry_c;
      ovf_q    <= ovf_c;
      id_q     <= winner;
      rr_ptr   <= ID_W'(next_rr_idx(32'(winner), NUM_REQ));
    end
  end

  assign bus.rsp_valid  = (slot_q == SLOT_FULL);
  assign bus.rsp_result = result_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.rsp_id     = id_q;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Bench for addsub_rr_scheduler (N=8, NUM_REQ=4): directed vectors, corner
// sequences and random traffic against a per-cycle behavioural model.
module tb_addsub_rr_scheduler;

  localparam int unsigned N  = 8;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  addsub_rr_scheduler_if #(.N(N), .NUM_REQ(NR)) bus ();

  addsub_rr_scheduler #(.N(N), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model state.
  int         m_ptr;
  logic       m_valid;
  logic [7:0] m_res;
  logic       m_carry;
  logic       m_ovf;
  logic [1:0] m_id;

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] res;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs[5];
  int   rr_exp[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic logic [31:0] pk(input int req, input logic [7:0] v);
    logic [31:0] r;
    r = '0;
    r[req*8 +: 8] = v;
    return r;
  endfunction

  // One clock: drive inputs, check against the model mid-cycle, advance the model.
  task automatic tick(input logic [3:0] vld, input logic [31:0] a_pk, input logic [31:0] b_pk,
                      input logic [3:0] op, input logic rdy, input logic r);
    logic [3:0] exp_ready;
    int         win;
    int         idx;
    int         ai, bi, s, sv;
    rst           = r;
    bus.req_valid = vld;
    bus.req_a     = a_pk;
    bus.req_b     = b_pk;
    bus.req_op    = op;
    bus.rsp_ready = rdy;
    exp_ready     = '0;
    win           = -1;
    if (!r) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (win < 0 && vld[idx]) win = idx;
      end
      if (win >= 0 && (!m_valid || rdy)) exp_ready[win] = 1'b1;
    end
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("rsp_regs", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_ovf, bus.rsp_id}),
        64'({m_valid, m_res, m_carry, m_ovf, m_id}));
    if (r) begin
      m_valid = 1'b0; m_res = '0; m_carry = 1'b0; m_ovf = 1'b0; m_id = '0; m_ptr = 0;
    end else if (exp_ready != '0) begin
      ai = int'(a_pk[win*8 +: 8]);
      bi = int'(b_pk[win*8 +: 8]);
      if (op[win]) begin
        s  = ai - bi;
        sv = sval(ai) - sval(bi);
        m_carry = (ai >= bi);
      end else begin
        s  = ai + bi;
        sv = sval(ai) + sval(bi);
        m_carry = (s > 255);
      end
      m_res   = 8'(s & 255);
      m_ovf   = (sv > 127) || (sv < -128);
      m_valid = 1'b1;
      m_id    = 2'(win);
      m_ptr   = (win + 1) % 4;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{req: 2, a: 8'h05, b: 8'h03, op: 1'b1, res: 8'h02, carry: 1'b1, ovf: 1'b0};
    vecs[1] = '{req: 0, a: 8'h03, b: 8'h05, op: 1'b1, res: 8'hFE, carry: 1'b0, ovf: 1'b0};
    vecs[2] = '{req: 0, a: 8'h7F, b: 8'h01, op: 1'b0, res: 8'h80, carry: 1'b0, ovf: 1'b1};
    vecs[3] = '{req: 0, a: 8'hFF, b: 8'h01, op: 1'b0, res: 8'h00, carry: 1'b1, ovf: 1'b0};
    vecs[4] = '{req: 1, a: 8'h80, b: 8'h01, op: 1'b1, res: 8'h7F, carry: 1'b1, ovf: 1'b1};
    rr_exp  = '{0, 1, 2, 3, 0};

    m_ptr = 0; m_valid = 1'b0; m_res = '0; m_carry = 1'b0; m_ovf = 1'b0; m_id = '0;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    tick(4'b0000, '0, '0, '0, 1'b0, 1'b1);
    chk("reset_state", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_ovf, bus.rsp_id}), 64'(0));

    // Arithmetic table: one request per cycle, result checked the cycle after.
    for (int i = 0; i < 5; i++) begin
      tick(4'(1 << vecs[i].req), pk(vecs[i].req, vecs[i].a), pk(vecs[i].req, vecs[i].b),
           4'(vecs[i].op) << vecs[i].req, 1'b1, 1'b0);
      chk("vec_rsp", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_ovf, 2'(bus.rsp_id)}),
          64'({1'b1, vecs[i].res, vecs[i].carry, vecs[i].ovf, 2'(vecs[i].req)}));
    end

    // Round-robin order from a fresh reset.
    tick(4'b0000, '0, '0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick(4'b1111, $urandom, $urandom, 4'($urandom), 1'b1, 1'b0);
      chk("rr_id", 64'({bus.rsp_valid, bus.rsp_id}), 64'({1'b1, 2'(rr_exp[k])}));
    end

    // Backpressure: slot holds id=1 / 0x10 while req 3 waits.
    tick(4'b0010, pk(1, 8'h08), pk(1, 8'h08), 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(4'b1000, pk(3, 8'h20), pk(3, 8'h01), 4'b1000, 1'b0, 1'b0);
      chk("bp_stable", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_id}), 64'({1'b1, 8'h10, 2'd1}));
    end
    tick(4'b1000, pk(3, 8'h20), pk(3, 8'h01), 4'b1000, 1'b1, 1'b0);
    chk("bp_release", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_id}), 64'({1'b1, 8'h1F, 2'd3}));

    // Skip idle requesters, starting from rr_ptr=2.
    tick(4'b0010, '0, '0, '0, 1'b1, 1'b0);
    tick(4'b1010, $urandom, $urandom, '0, 1'b1, 1'b0);
    chk("skip_first", 64'(bus.rsp_id), 64'(3));
    tick(4'b1010, $urandom, $urandom, '0, 1'b1, 1'b0);
    chk("skip_second", 64'(bus.rsp_id), 64'(1));
    tick(4'b1111, $urandom, $urandom, '0, 1'b1, 1'b0);
    chk("skip_ptr_end", 64'(bus.rsp_id), 64'(2));

    // Reset while a response is pending and req 2 is waiting.
    tick(4'b0100, $urandom, $urandom, '0, 1'b0, 1'b0);
    tick(4'b0100, $urandom, $urandom, '0, 1'b0, 1'b1);
    chk("rst_clear", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_ovf, bus.rsp_id}), 64'(0));
    tick(4'b0101, $urandom, $urandom, '0, 1'b1, 1'b0);
    chk("rst_first", 64'({bus.rsp_valid, bus.rsp_id}), 64'({1'b1, 2'd0}));
    tick(4'b0100, $urandom, $urandom, '0, 1'b1, 1'b0);
    chk("rst_second", 64'({bus.rsp_valid, bus.rsp_id}), 64'({1'b1, 2'd2}));

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      tick(4'($urandom), $urandom, $urandom, 4'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end
    tick(4'b0000, '0, '0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
Shares one N-bit add/subtract datapath among NUM_REQ requesters using round-robin arbitration. Each requester presents operands and an opcode on a valid/ready handshake. The winning operation is computed and captured in a single output register. Results return on one response channel tagged with the requester ID, with full backpressure. The block sits between multiple issuing engines and the single shared adder/subtractor.

Parameters:
- N, 8, operand/result width in bits.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of requester ID (derived; not overridden).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*N  operand A, packed; requester i at [i*N +: N].
- req_b  in  NUM_REQ*N  operand B, packed likewise.
- req_op  in  NUM_REQ  per-requester opcode; 0 = A+B, 1 = A-B.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  downstream accepts the response.
- rsp_result  out  N  sum or difference, modulo 2^N.
- rsp_carry  out  1  carry-out of A+B (op=0), or of A+~B+1 (op=1); for subtract, 1 = no borrow.
- rsp_ovf  out  1  two's-complement signed overflow.
- rsp_id  out  ID_W  index of the requester that issued the result.

Behaviour:
- Reset (rst=1 at a clock edge): rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_ovf=0, rsp_id=0, rr_ptr=0. req_ready is combinational and is 0 during reset.
- Slot FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on rsp_ready with no grant.
  - FULL -> FULL when rsp_ready and a grant occur in the same cycle (back-to-back; the result is replaced).
  - FULL holds when rsp_ready=0; rsp_* are stable while rsp_valid=1 and rsp_ready=0.
- Grant enable: can_issue = !rsp_valid || rsp_ready.
- Arbitration:
  - Among i with req_valid[i]=1, pick the first found searching from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready[winner] = can_issue; all other bits are 0.
  - req_ready may depend combinationally on req_valid and rsp_ready; there is no combinational path from req_a/req_b/req_op.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i].
- On transfer:
  - Capture the datapath outputs for the winner's operands into rsp_result/rsp_carry/rsp_ovf.
  - rsp_id <= winner.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - rr_ptr changes only on a transfer.
- Latency: exactly 1 cycle, from the accepting edge to rsp_valid=1. Throughput is 1 op/cycle when rsp_ready is held high.
- Arithmetic:
  - temp = op ? ~B : B.
  - {carry, result} = A + temp + op, computed at N+1 bits.
  - ovf = (A[N-1] == temp[N-1]) && (result[N-1] != A[N-1]).
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- Requesters must hold req_valid and operands until accepted. Dropping req_valid early is legal: that request is simply not granted.
- Reset mid-operation: a pending response is discarded without a handshake. Arbitration restarts at requester 0 on the first cycle after reset.
- No requests and slot EMPTY: the block is idle and state holds.

Decomposition:
- Shared package addsub_sched_pkg:
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1;
  - the slot-state enum {SLOT_EMPTY, SLOT_FULL};
  - a function computing next round-robin index.
- One natural sub-module: the existing combinational nbit_add_sub datapath, instantiated once and fed from the winner mux. Overflow is derived in the scheduler from the operands and result.
- Arbiter logic stays inline; no separate module.

Test Plan (N=8, NUM_REQ=4):
- Single subtract, no borrow: req 2 sends A=0x05, B=0x03, op=1; rsp_ready=1 -> next cycle rsp_valid=1, result=0x02, carry=1, ovf=0, id=2.
- Borrow and add-overflow: req 0 sends A=0x03, B=0x05, op=1 -> result=0xFE, carry=0. Then A=0x7F, B=0x01, op=0 -> result=0x80, carry=0, ovf=1. Then A=0xFF, B=0x01, op=0 -> 0x00, carry=1, ovf=0.
- Round-robin: all four requesters valid continuously, rsp_ready=1, rr_ptr=0 after reset -> grants in order 0,1,2,3,0; one response per cycle with ids 0,1,2,3,0.
- Backpressure: slot FULL with id=1 result 0x10, rsp_ready=0 for 3 cycles while req 3 is valid -> req_ready=0 and rsp_* stable throughout. On rsp_ready=1, req 3 is granted the same cycle and its result appears the next cycle.
- Skip idle requesters: only req 1 and req 3 valid, rr_ptr=2 -> req 3 first, then req 1; rr_ptr ends at 2.
- Reset mid-operation: assert rst while rsp_valid=1 and req 2 is valid -> next cycle rsp_valid=0, rsp_*=0. After rst deasserts, a request from req 0 is granted before one from req 2.
